// File: rtl/int_sequencer.sv
// Four-source interrupt sequencer: synchronizes and debounces active-low keys,
// latches press edges as pending flags and hands the winner to the fetch stage.
module int_sequencer #(
    parameter int NSRC      = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NSRC-1:0] i_irq_n,
    input  logic [NSRC-1:0] i_mask,
    input  logic            i_ie,
    input  logic            i_stall,
    input  logic            i_eret,
    output logic            o_int,
    output logic [31:0]     o_cause,
    output logic [1:0]      o_id,
    output logic [NSRC-1:0] o_pending,
    output logic            o_busy,
    output logic [1:0]      o_state
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [NSRC-1:0] sync1_q, sync2_q;
    logic [NSRC-1:0] filt_q, filt_d, filt_prev_q;
    logic [CW-1:0]   cnt_q [NSRC];
    logic [CW-1:0]   cnt_d [NSRC];
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] press, clr, elig, onehot_id;
    logic [1:0]      state_q, state_d;
    logic [1:0]      id_q, id_d, win_id;
    logic [31:0]     cause_q, cause_d;
    logic            int_req;

    // The filtered level flips only after DB_CYCLES back-to-back samples that disagree with it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int s = 0; s < NSRC; s++) begin
            if (sync2_q[s] != filt_q[s]) begin
                if (cnt_q[s] == CW'(DB_CYCLES - 1)) begin
                    filt_d[s] = sync2_q[s];
                    cnt_d[s]  = '0;
                end else begin
                    cnt_d[s] = cnt_q[s] + 1'b1;
                end
            end else begin
                cnt_d[s] = '0;
            end
        end
    end

    assign press     = filt_prev_q & ~filt_q;
    assign elig      = pending_q & i_mask & {NSRC{i_ie}};
    assign onehot_id = NSRC'(1) << id_q;

    always_comb begin
        win_id = '0;
        for (int s = NSRC - 1; s >= 0; s--) begin
            if (elig[s]) win_id = 2'(s);
        end
    end

    // o_int is a one-cycle request that is its own acknowledge: it rises only in
    // the cycle fetch is not stalled, and that cycle commits EPC/Cause.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cause_d = cause_q;
        clr     = '0;
        int_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    state_d = ST_REQ;
                    id_d    = win_id;
                end
            end
            ST_REQ: begin
                if (!i_ie || !i_mask[id_q]) begin
                    state_d = ST_IDLE;
                end else if (!i_stall) begin
                    int_req = 1'b1;
                    cause_d = {20'b0, onehot_id, 8'h00};
                    clr     = onehot_id;
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (i_eret) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pending_d = (pending_q & ~clr) | press;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            filt_q      <= '1;
            filt_prev_q <= '1;
            for (int s = 0; s < NSRC; s++) cnt_q[s] <= '0;
            pending_q   <= '0;
            state_q     <= ST_IDLE;
            id_q        <= '0;
            cause_q     <= '0;
        end else begin
            sync1_q     <= i_irq_n;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            id_q        <= id_d;
            cause_q     <= cause_d;
        end
    end

    assign o_int     = int_req;
    assign o_cause   = cause_q;
    assign o_id      = id_q;
    assign o_pending = pending_q;
    assign o_busy    = (state_q == ST_SERVICE);
    assign o_state   = state_q;
endmodule

// File: doc/int_sequencer.md
INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 Parameter NSRC, default 4, number of external interrupt sources; only 4 is supported.
REQ-002 Parameter DB_CYCLES, default 4, number of consecutive stable sampled cycles required to accept a level change.
REQ-003 Clk  input  1  single system clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 i_irq_n  input  4  raw asynchronous active-low request lines (keys); bit 0 is highest priority.
REQ-006 i_mask  input  4  per-source enable, wired from Status[11:8].
REQ-007 i_ie  input  1  global interrupt enable, wired from Status[0].
REQ-008 i_stall  input  1  fetch stall (StallF); an interrupt is accepted only in a cycle where it is low.
REQ-009 i_eret  input  1  return-from-exception pulse from decode.
REQ-010 o_int  output  1  redirect request to the PC mux, EPC write enable and Cause write enable.
REQ-011 o_cause  output  32  cause word {20'b0, one-hot serviced source in [11:8], 8'h00}.
REQ-012 o_id  output  2  index of the source being requested or serviced.
REQ-013 o_pending  output  4  latched pending flags.
REQ-014 o_busy  output  1  high while in SERVICE.

Function
REQ-015 Each i_irq_n bit shall pass through a two-flop synchronizer before any other use.
REQ-016 Each synchronized bit shall feed a debouncer: the filtered level changes only after DB_CYCLES consecutive identical samples that differ from the current filtered level; the counter restarts on any mismatch.
REQ-017 A 1->0 transition of a filtered level shall set that source's pending bit on the next edge (press edge); level-held inputs shall not re-trigger.
REQ-018 Eligible set = o_pending & i_mask, gated by i_ie; the winner is the lowest-index eligible bit.
REQ-019 FSM states: IDLE, REQ, SERVICE.
REQ-020 IDLE: a nonzero eligible set moves to REQ and latches the winner into o_id; o_int=0.
REQ-021 REQ: o_int=1 combinationally while the state is REQ and i_stall=0; o_int=0 while i_stall=1, and the state holds.
REQ-022 REQ with i_stall=0 (accept cycle): load o_cause for o_id, clear pending[o_id], go to SERVICE.
REQ-023 REQ: if i_ie=0 or i_mask[o_id]=0 before accept, return to IDLE with pending retained and o_int=0.
REQ-024 REQ: o_id is frozen; a higher-priority arrival does not preempt.
REQ-025 SERVICE: o_busy=1 and o_int=0; no new request is raised; pending bits still accumulate.
REQ-026 SERVICE with i_eret=1: return to IDLE next cycle; o_cause holds its value.
REQ-027 i_eret in IDLE or REQ shall be ignored.
REQ-028 When a set and a clear of the same pending bit occur in one cycle, set wins.
REQ-029 Accept-to-redirect latency: o_int is asserted in the accept cycle itself; the earliest accept is 1 cycle after the pending set.
REQ-030 Press-to-pending latency: 2 synchronizer cycles + DB_CYCLES + 1 cycle.

Reset
REQ-031 When Reset=0, the block shall immediately enter IDLE and force o_int=0, o_cause=0, o_id=0, o_pending=0, o_busy=0, synchronizers=1 (released), filtered levels=1, counters=0.
REQ-032 Reset asserted in REQ or SERVICE shall abort with no accept and no pending retained.
REQ-033 After Reset deasserts, a key held low shall produce one pending set once debounced.

Verification
REQ-034 Single press: i_ie=1, i_mask=4'hF, i_stall=0, i_irq_n[1] low for 10 cycles -> pending[1] set at cycle 7 -> o_int=1 for one cycle -> o_cause=32'h00000200, o_id=1, o_busy=1.
REQ-035 Priority: bits 0 and 2 pressed in the same cycle -> source 0 serviced first (o_cause=32'h00000100); after i_eret, source 2 is serviced (o_cause=32'h00000400).
REQ-036 Stall and withdraw: REQ with i_stall=1 for 3 cycles -> o_int=0 and state holds; then i_stall=0 -> accept. Repeat with i_ie dropped during the stall -> IDLE, pending stays 1.
REQ-037 Bounce: glitch lasting DB_CYCLES-1 cycles -> no pending set; a press during SERVICE -> pending set, serviced only after i_eret.
REQ-038 Async reset asserted mid-SERVICE with pending=4'b0101 -> all outputs 0 within the same cycle, without waiting for a clock edge.
